// File: rtl/axonerve_kvs_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axonerve_kvs_arbiter_if                                                |
// | Requester, kernel command/result and control bundle of the KVS arbiter |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface axonerve_kvs_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 16
);
    localparam int CNTW = $clog2(TAG_DEPTH) + 1;

    logic [NUM_REQ-1:0]     I_REQ_VALID;
    logic [NUM_REQ-1:0]     O_REQ_READY;
    logic [NUM_REQ*3-1:0]   I_REQ_OP;
    logic [NUM_REQ*128-1:0] I_REQ_KEY_DAT;
    logic [NUM_REQ*128-1:0] I_REQ_EKEY_MSK;
    logic [NUM_REQ*7-1:0]   I_REQ_KEY_PRI;
    logic [NUM_REQ*32-1:0]  I_REQ_KEY_VALUE;

    logic                   O_CMD_VALID;
    logic                   O_CMD_ERASE;
    logic                   O_CMD_WRITE;
    logic                   O_CMD_READ;
    logic                   O_CMD_SEARCH;
    logic                   O_CMD_UPDATE;
    logic [127:0]           O_KEY_DAT;
    logic [127:0]           O_EKEY_MSK;
    logic [6:0]             O_KEY_PRI;
    logic [31:0]            O_KEY_VALUE;

    logic                   I_READY;
    logic                   I_WAIT;
    logic                   I_CMD_FULL;
    logic                   I_ACK;
    logic                   I_ENT_ERR;
    logic                   I_SINGLE_HIT;
    logic                   I_MULTI_HIT;
    logic [31:0]            I_KEY_VALUE;

    logic [NUM_REQ-1:0]     O_RSP_VALID;
    logic                   O_RSP_ENT_ERR;
    logic                   O_RSP_SHIT;
    logic                   O_RSP_MHIT;
    logic [31:0]            O_RSP_KEY_VALUE;

    logic                   I_DRAIN;
    logic                   O_DRAINED;
    logic [CNTW-1:0]        O_OUTSTANDING;
    logic                   O_ORPHAN_ACK;

    modport slave (
        input  I_REQ_VALID, I_REQ_OP, I_REQ_KEY_DAT, I_REQ_EKEY_MSK, I_REQ_KEY_PRI, I_REQ_KEY_VALUE,
        output O_REQ_READY,
        output O_CMD_VALID, O_CMD_ERASE, O_CMD_WRITE, O_CMD_READ, O_CMD_SEARCH, O_CMD_UPDATE,
        output O_KEY_DAT, O_EKEY_MSK, O_KEY_PRI, O_KEY_VALUE,
        input  I_READY, I_WAIT, I_CMD_FULL, I_ACK, I_ENT_ERR, I_SINGLE_HIT, I_MULTI_HIT, I_KEY_VALUE,
        output O_RSP_VALID, O_RSP_ENT_ERR, O_RSP_SHIT, O_RSP_MHIT, O_RSP_KEY_VALUE,
        input  I_DRAIN,
        output O_DRAINED, O_OUTSTANDING, O_ORPHAN_ACK
    );

    modport master (
        output I_REQ_VALID, I_REQ_OP, I_REQ_KEY_DAT, I_REQ_EKEY_MSK, I_REQ_KEY_PRI, I_REQ_KEY_VALUE,
        input  O_REQ_READY,
        input  O_CMD_VALID, O_CMD_ERASE, O_CMD_WRITE, O_CMD_READ, O_CMD_SEARCH, O_CMD_UPDATE,
        input  O_KEY_DAT, O_EKEY_MSK, O_KEY_PRI, O_KEY_VALUE,
        output I_READY, I_WAIT, I_CMD_FULL, I_ACK, I_ENT_ERR, I_SINGLE_HIT, I_MULTI_HIT, I_KEY_VALUE,
        input  O_RSP_VALID, O_RSP_ENT_ERR, O_RSP_SHIT, O_RSP_MHIT, O_RSP_KEY_VALUE,
        output I_DRAIN,
        input  O_DRAINED, O_OUTSTANDING, O_ORPHAN_ACK
    );
endinterface
`default_nettype wire

// File: rtl/axonerve_kvs_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axonerve_kvs_arbiter                                                   |
// | Round-robin sharing of one KVS kernel command port, in-order responses |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module axonerve_kvs_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 16
) (
    input  wire logic             I_CLK,
    input  wire logic             I_XRST,
    axonerve_kvs_arbiter_if.slave bus
);
    localparam int IDXW = $clog2(NUM_REQ);
    localparam int PTRW = $clog2(TAG_DEPTH);
    localparam int CNTW = PTRW + 1;

    localparam logic [1:0] c_S_INIT  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_HOLD  = 2'd3;

    localparam logic [CNTW-1:0] c_TAG_FULL = CNTW'(TAG_DEPTH);

    logic [1:0]         r_state;
    logic [IDXW-1:0]    r_rr;
    logic [IDXW-1:0]    r_fifo [TAG_DEPTH];
    logic [PTRW-1:0]    r_wptr;
    logic [PTRW-1:0]    r_rptr;
    logic [CNTW-1:0]    r_count;

    logic               r_cmd_valid;
    logic               r_cmd_erase;
    logic               r_cmd_write;
    logic               r_cmd_read;
    logic               r_cmd_search;
    logic               r_cmd_update;
    logic [127:0]       r_key_dat;
    logic [127:0]       r_ekey_msk;
    logic [6:0]         r_key_pri;
    logic [31:0]        r_key_value;

    logic [NUM_REQ-1:0] r_rsp_valid;
    logic               r_rsp_ent_err;
    logic               r_rsp_shit;
    logic               r_rsp_mhit;
    logic [31:0]        r_rsp_key_value;
    logic               r_orphan;

    logic               w_issue_ok;
    logic               w_found;
    logic [IDXW-1:0]    w_gidx;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_accept;
    logic               w_pop;
    logic [IDXW:0]      w_sum  [NUM_REQ];
    logic [IDXW-1:0]    w_cand [NUM_REQ];
    logic [IDXW-1:0]    w_rr_next;

    logic [2:0]         w_sel_op;
    logic [127:0]       w_sel_key;
    logic [127:0]       w_sel_msk;
    logic [6:0]         w_sel_pri;
    logic [31:0]        w_sel_val;
    logic               w_dec_search;
    logic               w_dec_write;
    logic               w_dec_erase;
    logic               w_dec_update;
    logic               w_dec_read;
    logic               w_op_legal;

    assign w_issue_ok = (r_state == c_S_RUN) && bus.I_READY && !bus.I_WAIT &&
                        !bus.I_CMD_FULL && (r_count < c_TAG_FULL);

    // Candidate i is the requester i places after the round-robin pointer.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cand
        assign w_sum[g]  = {1'b0, r_rr} + (IDXW+1)'(g);
        assign w_cand[g] = (w_sum[g] >= (IDXW+1)'(NUM_REQ)) ?
                           IDXW'(w_sum[g] - (IDXW+1)'(NUM_REQ)) : IDXW'(w_sum[g]);
    end

    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && bus.I_REQ_VALID[w_cand[i]]) begin
                w_found = 1'b1;
                w_gidx  = w_cand[i];
            end
        end
        if (w_issue_ok && w_found) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    assign w_accept  = |(w_grant & bus.I_REQ_VALID);
    assign w_pop     = bus.I_ACK && (r_count != '0);
    assign w_rr_next = (w_gidx == IDXW'(NUM_REQ - 1)) ? '0 : w_gidx + IDXW'(1);

    always_comb begin
        w_sel_op  = '0;
        w_sel_key = '0;
        w_sel_msk = '0;
        w_sel_pri = '0;
        w_sel_val = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gidx == IDXW'(i)) begin
                w_sel_op  = bus.I_REQ_OP[i*3 +: 3];
                w_sel_key = bus.I_REQ_KEY_DAT[i*128 +: 128];
                w_sel_msk = bus.I_REQ_EKEY_MSK[i*128 +: 128];
                w_sel_pri = bus.I_REQ_KEY_PRI[i*7 +: 7];
                w_sel_val = bus.I_REQ_KEY_VALUE[i*32 +: 32];
            end
        end
    end

    assign w_dec_search = (w_sel_op == 3'd0);
    assign w_dec_write  = (w_sel_op == 3'd1);
    assign w_dec_erase  = (w_sel_op == 3'd2);
    assign w_dec_update = (w_sel_op == 3'd3);
    assign w_dec_read   = (w_sel_op == 3'd4);
    assign w_op_legal   = (w_sel_op <= 3'd4);

    // Tag storage needs no reset: it is only read while r_count is non-zero.
    always_ff @(posedge I_CLK) begin
        if (w_accept) begin
            r_fifo[r_wptr] <= w_gidx;
        end
    end

    always_ff @(posedge I_CLK or negedge I_XRST) begin
        if (!I_XRST) begin
            r_state         <= c_S_INIT;
            r_rr            <= '0;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
            r_cmd_valid     <= 1'b0;
            r_cmd_erase     <= 1'b0;
            r_cmd_write     <= 1'b0;
            r_cmd_read      <= 1'b0;
            r_cmd_search    <= 1'b0;
            r_cmd_update    <= 1'b0;
            r_key_dat       <= '0;
            r_ekey_msk      <= '0;
            r_key_pri       <= '0;
            r_key_value     <= '0;
            r_rsp_valid     <= '0;
            r_rsp_ent_err   <= 1'b0;
            r_rsp_shit      <= 1'b0;
            r_rsp_mhit      <= 1'b0;
            r_rsp_key_value <= '0;
            r_orphan        <= 1'b0;
        end else begin
            r_cmd_valid  <= w_accept;
            r_cmd_search <= w_accept && w_dec_search;
            r_cmd_write  <= w_accept && w_dec_write;
            r_cmd_erase  <= w_accept && w_dec_erase;
            r_cmd_update <= w_accept && w_dec_update;
            r_cmd_read   <= w_accept && w_dec_read;
            if (w_accept) begin
                r_key_dat   <= w_sel_key;
                r_ekey_msk  <= w_sel_msk;
                r_key_pri   <= w_sel_pri;
                r_key_value <= w_op_legal ? w_sel_val : 32'd0;
                r_rr        <= w_rr_next;
            end
            r_rsp_valid <= '0;
            if (!bus.I_READY) begin
                // Kernel lost: every outstanding tag is meaningless now.
                r_state <= c_S_INIT;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                case (r_state)
                    c_S_INIT:  r_state <= c_S_RUN;
                    c_S_RUN:   if (bus.I_DRAIN)       r_state <= c_S_DRAIN;
                    c_S_DRAIN: if (r_count == '0)     r_state <= c_S_HOLD;
                    c_S_HOLD:  if (!bus.I_DRAIN)      r_state <= c_S_RUN;
                    default:   r_state <= c_S_INIT;
                endcase
                if (w_accept) begin
                    r_wptr <= r_wptr + PTRW'(1);
                end
                if (w_pop) begin
                    r_rptr          <= r_rptr + PTRW'(1);
                    r_rsp_valid     <= NUM_REQ'(1) << r_fifo[r_rptr];
                    r_rsp_ent_err   <= bus.I_ENT_ERR;
                    r_rsp_shit      <= bus.I_SINGLE_HIT;
                    r_rsp_mhit      <= bus.I_MULTI_HIT;
                    r_rsp_key_value <= bus.I_KEY_VALUE;
                end
                if (bus.I_ACK && (r_count == '0)) begin
                    r_orphan <= 1'b1;
                end
                case ({w_accept, w_pop})
                    2'b10:   r_count <= r_count + CNTW'(1);
                    2'b01:   r_count <= r_count - CNTW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign bus.O_REQ_READY     = w_grant;
    assign bus.O_CMD_VALID     = r_cmd_valid;
    assign bus.O_CMD_ERASE     = r_cmd_erase;
    assign bus.O_CMD_WRITE     = r_cmd_write;
    assign bus.O_CMD_READ      = r_cmd_read;
    assign bus.O_CMD_SEARCH    = r_cmd_search;
    assign bus.O_CMD_UPDATE    = r_cmd_update;
    assign bus.O_KEY_DAT       = r_key_dat;
    assign bus.O_EKEY_MSK      = r_ekey_msk;
    assign bus.O_KEY_PRI       = r_key_pri;
    assign bus.O_KEY_VALUE     = r_key_value;
    assign bus.O_RSP_VALID     = r_rsp_valid;
    assign bus.O_RSP_ENT_ERR   = r_rsp_ent_err;
    assign bus.O_RSP_SHIT      = r_rsp_shit;
    assign bus.O_RSP_MHIT      = r_rsp_mhit;
    assign bus.O_RSP_KEY_VALUE = r_rsp_key_value;
    assign bus.O_DRAINED       = (r_state == c_S_HOLD);
    assign bus.O_OUTSTANDING   = r_count;
    assign bus.O_ORPHAN_ACK    = r_orphan;
endmodule
`default_nettype wire

// File: tb/tb_axonerve_kvs_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_axonerve_kvs_arbiter                                                |
// | Directed and random stimulus against a queue-based reference model     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_axonerve_kvs_arbiter;
    localparam int NR = 4;
    localparam int TD = 16;
    localparam int M_INIT = 0, M_RUN = 1, M_DRAIN = 2, M_HOLD = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axonerve_kvs_arbiter_if #(.NUM_REQ(NR), .TAG_DEPTH(TD)) bus ();

    axonerve_kvs_arbiter #(.NUM_REQ(NR), .TAG_DEPTH(TD)) dut (
        .I_CLK  (clk),
        .I_XRST (rst_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode, queue of issuing requester indices, rr pointer,
    // and the registered outputs expected after the next clock edge.
    int           m_mode;
    int           m_q[$];
    int           m_rr;
    logic         e_cmd_valid;
    logic [4:0]   e_flags;   // {erase, write, read, search, update}
    logic [127:0] e_key, e_msk;
    logic [6:0]   e_pri;
    logic [31:0]  e_val;
    logic [3:0]   e_rsp_valid;
    logic         e_err, e_shit, e_mhit, e_orph;
    logic [31:0]  e_rval;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_INIT; m_q.delete(); m_rr = 0;
        e_cmd_valid = 0; e_flags = '0; e_key = '0; e_msk = '0; e_pri = '0; e_val = '0;
        e_rsp_valid = '0; e_err = 0; e_shit = 0; e_mhit = 0; e_rval = '0; e_orph = 0;
    endtask

    task automatic idle_inputs();
        bus.I_REQ_VALID = '0; bus.I_REQ_OP = '0; bus.I_REQ_KEY_DAT = '0;
        bus.I_REQ_EKEY_MSK = '0; bus.I_REQ_KEY_PRI = '0; bus.I_REQ_KEY_VALUE = '0;
        bus.I_READY = 0; bus.I_WAIT = 0; bus.I_CMD_FULL = 0; bus.I_ACK = 0;
        bus.I_ENT_ERR = 0; bus.I_SINGLE_HIT = 0; bus.I_MULTI_HIT = 0; bus.I_KEY_VALUE = '0;
        bus.I_DRAIN = 0;
    endtask

    task automatic set_req(input int r, input logic [2:0] op, input logic [127:0] key);
        bus.I_REQ_OP[r*3 +: 3]          = op;
        bus.I_REQ_KEY_DAT[r*128 +: 128] = key;
        bus.I_REQ_EKEY_MSK[r*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        bus.I_REQ_KEY_PRI[r*7 +: 7]     = 7'($urandom);
        bus.I_REQ_KEY_VALUE[r*32 +: 32] = $urandom;
    endtask

    task automatic rand_reqs();
        bus.I_REQ_VALID = 4'($urandom);
        for (int r = 0; r < NR; r++) set_req(r, 3'($urandom), {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic set_ack(input logic ack, input logic err, input logic sh, input logic mh);
        bus.I_ACK = ack; bus.I_ENT_ERR = err; bus.I_SINGLE_HIT = sh;
        bus.I_MULTI_HIT = mh; bus.I_KEY_VALUE = $urandom;
    endtask

    // Called at a falling edge with inputs already applied: compare, advance model, wait one cycle.
    task automatic cycle();
        int   g, h, pre_n, op;
        logic ok;
        logic [3:0] exp_ready;
        #1;
        ok = (m_mode == M_RUN) && bus.I_READY && !bus.I_WAIT && !bus.I_CMD_FULL && (m_q.size() < TD);
        g = -1;
        if (ok) begin
            for (int i = 0; i < NR; i++) begin
                if (g < 0 && bus.I_REQ_VALID[(m_rr + i) % NR]) g = (m_rr + i) % NR;
            end
        end
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
        check("req_ready", bus.O_REQ_READY, exp_ready);
        check("cmd_valid", bus.O_CMD_VALID, e_cmd_valid);
        check("cmd_flags", {bus.O_CMD_ERASE, bus.O_CMD_WRITE, bus.O_CMD_READ,
                            bus.O_CMD_SEARCH, bus.O_CMD_UPDATE}, e_flags);
        if (e_cmd_valid) begin
            check("key_dat", bus.O_KEY_DAT, e_key);
            check("ekey_msk", bus.O_EKEY_MSK, e_msk);
            check("key_pri", bus.O_KEY_PRI, e_pri);
            check("key_value", bus.O_KEY_VALUE, e_val);
        end
        check("rsp_valid", bus.O_RSP_VALID, e_rsp_valid);
        if (e_rsp_valid != 0) begin
            check("rsp_flags", {bus.O_RSP_ENT_ERR, bus.O_RSP_SHIT, bus.O_RSP_MHIT}, {e_err, e_shit, e_mhit});
            check("rsp_value", bus.O_RSP_KEY_VALUE, e_rval);
        end
        check("outstanding", bus.O_OUTSTANDING, m_q.size());
        check("drained", bus.O_DRAINED, m_mode == M_HOLD);
        check("orphan", bus.O_ORPHAN_ACK, e_orph);

        pre_n = m_q.size();
        e_rsp_valid = '0;
        e_cmd_valid = (g >= 0);
        e_flags = '0;
        if (!bus.I_READY) begin
            m_q.delete();
            m_mode = M_INIT;
        end else begin
            if (g >= 0) begin
                op = int'(bus.I_REQ_OP[g*3 +: 3]);
                e_flags = {op == 2, op == 1, op == 4, op == 0, op == 3};
                e_key = bus.I_REQ_KEY_DAT[g*128 +: 128];
                e_msk = bus.I_REQ_EKEY_MSK[g*128 +: 128];
                e_pri = bus.I_REQ_KEY_PRI[g*7 +: 7];
                e_val = (op <= 4) ? bus.I_REQ_KEY_VALUE[g*32 +: 32] : 32'd0;
            end
            if (bus.I_ACK) begin
                if (pre_n > 0) begin
                    h = m_q.pop_front();
                    e_rsp_valid = 4'(1 << h);
                    e_err = bus.I_ENT_ERR; e_shit = bus.I_SINGLE_HIT;
                    e_mhit = bus.I_MULTI_HIT; e_rval = bus.I_KEY_VALUE;
                end else begin
                    e_orph = 1;
                end
            end
            if (g >= 0) begin
                m_q.push_back(g);
                m_rr = (g + 1) % NR;
            end
            case (m_mode)
                M_INIT:  m_mode = M_RUN;
                M_RUN:   if (bus.I_DRAIN) m_mode = M_DRAIN;
                M_DRAIN: if (pre_n == 0) m_mode = M_HOLD;
                default: if (!bus.I_DRAIN) m_mode = M_RUN;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready", bus.O_REQ_READY, 4'd0);
        check("rst_cmd", {bus.O_CMD_VALID, bus.O_CMD_ERASE, bus.O_CMD_WRITE, bus.O_CMD_READ,
                          bus.O_CMD_SEARCH, bus.O_CMD_UPDATE}, 6'd0);
        check("rst_payload", bus.O_KEY_DAT | bus.O_EKEY_MSK | 128'(bus.O_KEY_PRI) | 128'(bus.O_KEY_VALUE), 128'd0);
        check("rst_rsp", {bus.O_RSP_VALID, bus.O_RSP_ENT_ERR, bus.O_RSP_SHIT, bus.O_RSP_MHIT,
                          bus.O_RSP_KEY_VALUE}, 39'd0);
        check("rst_status", {bus.O_DRAINED, bus.O_OUTSTANDING, bus.O_ORPHAN_ACK}, 7'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        @(negedge clk); @(negedge clk);
        async_reset_check();

        // Single search from requester 0, then its ACK
        bus.I_READY = 1;
        cycle();
        bus.I_REQ_VALID = 4'b0001; set_req(0, 3'd0, 128'h5);
        cycle();
        bus.I_REQ_VALID = '0;
        cycle();
        set_ack(1, 0, 1, 0);
        cycle();
        set_ack(0, 0, 0, 0);
        cycles(2);

        // All requesters continuously: fills the tag FIFO, then full-state pop/push
        bus.I_REQ_VALID = 4'hF;
        for (int r = 0; r < NR; r++) set_req(r, 3'(r), {$urandom, $urandom, $urandom, $urandom});
        cycles(20);
        check("fifo_full", bus.O_OUTSTANDING, 5'd16);
        set_ack(1, 0, 0, 1);
        cycles(3);
        bus.I_REQ_VALID = '0;
        for (int i = 0; i < 18; i++) begin set_ack(1, 1'($urandom), 1'($urandom), 1'($urandom)); cycle(); end
        set_ack(0, 0, 0, 0);
        cycles(2);

        // Back-pressure from CMD_FULL then WAIT
        bus.I_REQ_VALID = 4'b0110;
        bus.I_CMD_FULL = 1; cycles(3);
        bus.I_CMD_FULL = 0; bus.I_WAIT = 1; cycles(3);
        bus.I_WAIT = 0; cycles(2);
        bus.I_REQ_VALID = '0;
        for (int i = 0; i < 3; i++) begin set_ack(1, 0, 0, 0); cycle(); end
        set_ack(0, 0, 0, 0); cycles(2);

        // Write from req2, erase from req1, responses routed in issue order
        bus.I_REQ_VALID = 4'b0100; set_req(2, 3'd1, 128'hABCD); cycle();
        bus.I_REQ_VALID = 4'b0010; set_req(1, 3'd2, 128'h1234); cycle();
        bus.I_REQ_VALID = '0; cycle();
        set_ack(1, 0, 1, 0); cycle();
        set_ack(1, 1, 0, 0); cycle();
        set_ack(0, 0, 0, 0); cycles(2);

        // Drain with three outstanding
        bus.I_REQ_VALID = 4'b1011; cycles(3);
        bus.I_REQ_VALID = '0; bus.I_DRAIN = 1; cycle();
        bus.I_REQ_VALID = 4'hF; cycles(2);
        for (int i = 0; i < 3; i++) begin set_ack(1, 0, 0, 0); cycle(); end
        set_ack(0, 0, 0, 0); cycles(3);
        check("drained_hold", bus.O_DRAINED, 1'b1);
        bus.I_DRAIN = 0; cycles(3);
        bus.I_REQ_VALID = '0;
        for (int i = 0; i < 3; i++) begin set_ack(1, 0, 0, 0); cycle(); end
        set_ack(0, 0, 0, 0); cycles(2);

        // Orphan ACK, then kernel READY drop with five outstanding
        set_ack(1, 0, 0, 0); cycle();
        set_ack(0, 0, 0, 0); cycles(2);
        bus.I_REQ_VALID = 4'hF; cycles(5);
        bus.I_REQ_VALID = '0; bus.I_READY = 0; cycles(2);
        check("ready_drop_flush", bus.O_OUTSTANDING, 5'd0);
        bus.I_READY = 1; cycles(2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_reqs();
            bus.I_WAIT     = ($urandom_range(0, 7) == 0);
            bus.I_CMD_FULL = ($urandom_range(0, 7) == 0);
            set_ack(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 39) == 0) bus.I_DRAIN = ~bus.I_DRAIN;
            bus.I_READY = ($urandom_range(0, 59) != 0);
            cycle();
        end
        idle_inputs(); bus.I_READY = 1;
        cycles(2);

        // Asynchronous reset in the middle of a burst
        bus.I_REQ_VALID = 4'hF; cycles(4);
        set_ack(1, 0, 1, 0); cycle();
        async_reset_check();
        bus.I_REQ_VALID = '0; set_ack(0, 0, 0, 0);
        cycles(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
